// File: rtl/game_sequencer.sv
// Game-flow controller for the space shooter: sequences idle/play/hit/over,
// keeps score and lives, and drives the sprite enable, invulnerability and flash controls.
module game_sequencer #(
    parameter int ASTEROID_COUNT = 10,
    parameter int LIVES          = 3,
    parameter int INVULN_FRAMES  = 120,
    parameter int FLASH_PERIOD   = 8,
    parameter int SCORE_MAX      = 999
) (
    input  logic                      clk_pix,
    input  logic                      reset_n,
    input  logic                      frame,
    input  logic                      start,
    input  logic                      collision,
    input  logic [ASTEROID_COUNT-1:0] asteroid_shot,
    output logic [1:0]                state,
    output logic                      play_en,
    output logic                      invuln,
    output logic                      flash,
    output logic [2:0]                lives,
    output logic [9:0]                score,
    output logic                      game_over
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_HIT  = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam int HW = $clog2(ASTEROID_COUNT + 1);

    logic start_meta_q, start_sync_q, start_prev_q;
    logic start_pending_q, start_pending_d;
    logic [1:0] state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [9:0] score_q, score_d;
    logic [7:0] invuln_cnt_q, invuln_cnt_d;
    logic [7:0] flash_cnt_q, flash_cnt_d;
    logic flash_q, flash_d;
    logic play_en_q, invuln_q, game_over_q;

    logic        start_rise;
    logic [HW-1:0] hits;
    logic [15:0] score_sum;
    logic [9:0]  score_sat;

    assign start_rise = start_sync_q & ~start_prev_q;

    always_comb begin
        hits = '0;
        for (int i = 0; i < ASTEROID_COUNT; i++) begin
            hits = hits + HW'(asteroid_shot[i]);
        end
    end

    // Wide sum so a near-maximum score plus a full volley clamps instead of wrapping.
    assign score_sum = 16'(score_q) + 16'(hits);
    assign score_sat = (score_sum > 16'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_sum[9:0];

    always_comb begin
        state_d         = state_q;
        lives_d         = lives_q;
        score_d         = score_q;
        invuln_cnt_d    = invuln_cnt_q;
        flash_cnt_d     = flash_cnt_q;
        flash_d         = flash_q;
        start_pending_d = start_pending_q | start_rise;

        if (frame) begin
            // The frame consumes any pending start; an edge landing on this very cycle waits for the next frame.
            start_pending_d = start_rise;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_pending_q) begin
                        state_d = ST_PLAY;
                        lives_d = 3'(LIVES);
                        score_d = '0;
                        flash_d = 1'b0;
                    end
                end
                ST_PLAY: begin
                    score_d = score_sat;
                    if (collision) begin
                        if (lives_q > 3'd1) begin
                            lives_d      = lives_q - 3'd1;
                            invuln_cnt_d = 8'(INVULN_FRAMES);
                            flash_cnt_d  = 8'(FLASH_PERIOD);
                            flash_d      = 1'b1;
                            state_d      = ST_HIT;
                        end else begin
                            lives_d = '0;
                            state_d = ST_OVER;
                        end
                    end
                end
                ST_HIT: begin
                    score_d      = score_sat;
                    invuln_cnt_d = invuln_cnt_q - 8'd1;
                    if (invuln_cnt_q <= 8'd1) begin
                        invuln_cnt_d = '0;
                        flash_cnt_d  = '0;
                        flash_d      = 1'b0;
                        state_d      = ST_PLAY;
                    end else if (flash_cnt_q <= 8'd1) begin
                        flash_cnt_d = 8'(FLASH_PERIOD);
                        flash_d     = ~flash_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q - 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            start_meta_q    <= 1'b0;
            start_sync_q    <= 1'b0;
            start_prev_q    <= 1'b0;
            start_pending_q <= 1'b0;
            state_q         <= ST_IDLE;
            lives_q         <= 3'(LIVES);
            score_q         <= '0;
            invuln_cnt_q    <= '0;
            flash_cnt_q     <= '0;
            flash_q         <= 1'b0;
            play_en_q       <= 1'b0;
            invuln_q        <= 1'b0;
            game_over_q     <= 1'b0;
        end else begin
            start_meta_q    <= start;
            start_sync_q    <= start_meta_q;
            start_prev_q    <= start_sync_q;
            start_pending_q <= start_pending_d;
            state_q         <= state_d;
            lives_q         <= lives_d;
            score_q         <= score_d;
            invuln_cnt_q    <= invuln_cnt_d;
            flash_cnt_q     <= flash_cnt_d;
            flash_q         <= flash_d;
            play_en_q       <= (state_d == ST_PLAY) || (state_d == ST_HIT);
            invuln_q        <= (state_d == ST_HIT);
            game_over_q     <= (state_d == ST_OVER);
        end
    end

    assign state     = state_q;
    assign play_en   = play_en_q;
    assign invuln    = invuln_q;
    assign flash     = flash_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign game_over = game_over_q;

endmodule
